// File: rtl/spi_txn_arbiter.sv
// rtl/spi_txn_arbiter.sv - round-robin sharing of one SPI byte engine across NUM_REQ requesters
// Optional macro SPI_ARB_TIMEOUT_EN aborts a transaction whose requester stalls for TIMEOUT cycles.
module spi_txn_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int CS_GUARD = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       rsp_valid,
  output logic [7:0]                 rsp_data,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [NUM_REQ-1:0]         cs_n,
  output logic                       eng_start,
  output logic [7:0]                 eng_tx,
  input  logic                       eng_busy,
  input  logic                       eng_done,
  input  logic [7:0]                 eng_rx,
  output logic                       err
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [3:0] GUARD = 4'(CS_GUARD);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_NEXT  = 3'd4;
  localparam logic [2:0] ST_HOLD  = 3'd5;

  logic [2:0]    state;
  logic [IW-1:0] grant;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] sel;
  logic [3:0]    gcnt;
  logic          last_q;
  logic          fire;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
`else
  assign err = 1'b0;
`endif

  // Walk downward so the requester closest to rr_ptr is written last and wins.
  always_comb begin
    sel = rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        sel = IW'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  assign fire = (state == ST_START) && req_valid[grant] && !eng_busy;

  // Handshake and chip selects decode straight from state so reset releases them at once.
  always_comb begin
    req_ready = '0;
    cs_n      = '1;
    eng_start = fire;
    eng_tx    = 8'h00;
    if (fire) begin
      req_ready[grant] = 1'b1;
      eng_tx           = req_data[grant*8 +: 8];
    end
    if (state != ST_IDLE) begin
      cs_n[grant] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      gcnt      <= '0;
      last_q    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      rsp_id    <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      tcnt      <= '0;
      err       <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      err       <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (|req_valid) begin
            grant <= sel;
            gcnt  <= GUARD;
            state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          gcnt <= gcnt - 4'd1;
          if (gcnt == 4'd1) begin
            state <= ST_START;
          end
        end
        ST_START: begin
          if (fire) begin
            last_q <= req_last[grant];
            state  <= ST_WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
            tcnt   <= '0;
`endif
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else if (!req_valid[grant]) begin
            if (tcnt == TW'(TIMEOUT - 1)) begin
              err   <= 1'b1;
              tcnt  <= '0;
              gcnt  <= GUARD;
              state <= ST_HOLD;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
`endif
        end
        ST_WAIT: begin
          if (eng_done) begin
            rsp_valid <= 1'b1;
            rsp_data  <= eng_rx;
            rsp_id    <= grant;
            if (last_q) begin
              gcnt  <= GUARD;
              state <= ST_HOLD;
            end else begin
              state <= ST_NEXT;
            end
          end
        end
        ST_NEXT: begin
          state <= ST_START;
        end
        ST_HOLD: begin
          gcnt <= gcnt - 4'd1;
          if (gcnt == 4'd1) begin
            state  <= ST_IDLE;
            rr_ptr <= (grant == IW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// tb/tb_spi_txn_arbiter.sv - self-checking bench for spi_txn_arbiter with a transaction-level model
// Timeout scenario runs only when SPI_ARB_TIMEOUT_EN is defined.
module tb_spi_txn_arbiter;
  localparam int N        = 2;
  localparam int CS_GUARD = 2;
  localparam int TIMEOUT  = 10;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic [7:0]     rsp_data;
  logic [0:0]     rsp_id;
  logic [N-1:0]   cs_n;
  logic           eng_start;
  logic [7:0]     eng_tx;
  logic           eng_busy;
  logic           eng_done;
  logic [7:0]     eng_rx;
  logic           err;

  always #5 clk = ~clk;

  spi_txn_arbiter #(.NUM_REQ(N), .CS_GUARD(CS_GUARD), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id), .cs_n(cs_n),
    .eng_start(eng_start), .eng_tx(eng_tx), .eng_busy(eng_busy), .eng_done(eng_done),
    .eng_rx(eng_rx), .err(err)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // stimulus: bit 8 marks the last byte of a transaction
  logic [8:0] stim [N][$];
  int d_pos [N];
  int m_pos [N];
  int gap [N];
  bit rand_gaps;

  int  m_ptr, mg;
  bit  in_txn, started, pend_last, hold_on, expect_abort, saw_err, spur;
  int  setup_cnt, setup_extra, hold_cnt, abort_at, rsp_due, exp_id;
  logic [7:0] exp_rx;

  bit  e_busy;
  int  e_cnt, lat_min, lat_max, busy_hold;
  logic [7:0] e_rx;
  logic [7:0] rx_plan [$];

  int grant_log [$];
  int rsp_id_log [$];
  logic [7:0] rsp_data_log [$];
  int n_start, n_ready;
  logic [N-1:0] rdy_obs;
  logic start_obs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int predict();
    for (int k = 0; k < N; k++) begin
      if (m_pos[(m_ptr + k) % N] < stim[(m_ptr + k) % N].size()) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic bit all_done();
    for (int i = 0; i < N; i++) begin
      if (d_pos[i] < stim[i].size() || m_pos[i] < stim[i].size()) return 1'b0;
    end
    return !in_txn && !e_busy && (rsp_due < cyc);
  endfunction

  task automatic drive_inputs();
    logic [8:0] b;
    for (int i = 0; i < N; i++) begin
      if (d_pos[i] < stim[i].size() && gap[i] == 0) begin
        b = stim[i][d_pos[i]];
        req_valid[i] = 1'b1;
        req_data[8*i +: 8] = b[7:0];
        req_last[i] = b[8];
      end else begin
        req_valid[i] = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i] = 1'b0;
      end
    end
  endtask

  task automatic bench_clear();
    for (int i = 0; i < N; i++) begin
      stim[i].delete();
      d_pos[i] = 0;
      m_pos[i] = 0;
      gap[i] = 0;
    end
    m_ptr = 0; mg = 0; in_txn = 0; started = 0; pend_last = 0; hold_on = 0;
    e_busy = 0; busy_hold = 0; rsp_due = -10; abort_at = -10; spur = 0;
    drive_inputs();
    eng_done = 1'b0; eng_busy = 1'b0; eng_rx = 8'h00;
  endtask

  task automatic step();
    int nlow, lowid;
    logic [8:0] b;
    @(negedge clk);
    cyc++;
    rdy_obs = req_ready;
    start_obs = eng_start;
    n_ready += $countones(rdy_obs);
    nlow = 0;
    lowid = -1;
    for (int i = 0; i < N; i++) begin
      if (cs_n[i] === 1'b0) begin
        nlow++;
        lowid = i;
      end
    end
    check("cs_onehot", nlow <= 1, 1);
    check("rsp_timing", rsp_valid, cyc == rsp_due);
    check("err_pulse", err, expect_abort && cyc == abort_at);
    if (in_txn && nlow == 0) begin
      check("hold_len", hold_on ? hold_cnt : -1, CS_GUARD);
      check("txn_complete", pend_last || (expect_abort && saw_err), 1);
      m_ptr = (mg + 1) % N;
      in_txn = 0;
    end else if (!in_txn && nlow == 1) begin
      mg = predict();
      check("grant", lowid, mg);
      grant_log.push_back(lowid);
      in_txn = 1; started = 0; setup_cnt = 0; pend_last = 0; hold_on = 0;
    end else if (in_txn) begin
      check("cs_owner", lowid, mg);
    end
    check("req_ready", rdy_obs, (in_txn && start_obs) ? (32'd1 << mg) : 32'd0);
    if (!in_txn) check("start_idle", start_obs, 0);
    if (in_txn && start_obs) begin
      if (!started) check("setup_len", setup_cnt, CS_GUARD + setup_extra);
      started = 1;
      n_start++;
      if (mg >= 0 && m_pos[mg] < stim[mg].size()) begin
        b = stim[mg][m_pos[mg]];
        check("eng_tx", eng_tx, b[7:0]);
        pend_last = b[8];
        m_pos[mg]++;
      end else begin
        check("eng_start_unexpected", start_obs, 0);
      end
    end else if (in_txn && !started) begin
      setup_cnt++;
    end
    if (rsp_valid === 1'b1) begin
      check("rsp_data", rsp_data, exp_rx);
      check("rsp_id", rsp_id, exp_id);
      rsp_data_log.push_back(rsp_data);
      rsp_id_log.push_back(int'(rsp_id));
      if (pend_last) begin
        hold_on = 1;
        hold_cnt = 0;
      end else if (expect_abort) begin
        abort_at = cyc + TIMEOUT + 1;
      end
    end
    if (err === 1'b1) begin
      saw_err = 1;
      hold_on = 1;
      hold_cnt = 0;
    end
    if (hold_on && nlow == 1) hold_cnt++;

    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (rdy_obs[i] && d_pos[i] < stim[i].size()) begin
        b = stim[i][d_pos[i]];
        d_pos[i]++;
        if (rand_gaps && !b[8]) gap[i] = $urandom_range(0, 3);
      end else if (gap[i] > 0) begin
        gap[i]--;
      end
    end
    drive_inputs();
    eng_done = 1'b0;
    if (start_obs) begin
      e_busy = 1;
      e_cnt = int'($urandom_range(lat_max, lat_min));
      e_rx = (rx_plan.size() > 0) ? rx_plan.pop_front() : 8'($urandom);
    end else if (e_busy) begin
      e_cnt--;
      if (e_cnt == 0) begin
        eng_done = 1'b1;
        eng_rx = e_rx;
        e_busy = 0;
        rsp_due = cyc + 2;
        exp_rx = e_rx;
        exp_id = mg;
      end
    end
    if (spur) begin
      eng_done = 1'b1;
      eng_rx = 8'hEE;
      spur = 0;
    end
    if (in_txn && busy_hold > 0) busy_hold--;
    eng_busy = e_busy || (busy_hold > 0);
  endtask

  task automatic run(input string tag, input int max);
    int k = 0;
    while (!all_done() && k < max) begin
      step();
      k++;
    end
    check({"done_", tag}, all_done(), 1);
  endtask

  task automatic clear_logs();
    grant_log.delete();
    rsp_id_log.delete();
    rsp_data_log.delete();
    n_start = 0;
    n_ready = 0;
  endtask

  initial begin
    int len, guard;
    rst = 1'b0;
    bench_clear();
    lat_min = 1; lat_max = 3; rand_gaps = 0; setup_extra = 0;
    expect_abort = 0; saw_err = 0;
    clear_logs();
    repeat (2) @(posedge clk);
    #1;
    check("rst_cs_n", cs_n, 2'b11);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_eng_start", eng_start, 0);
    check("rst_err", err, 0);
    check("rst_eng_tx", eng_tx, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_id", rsp_id, 0);
    rst = 1'b1;

    // eng_done while idle must not produce a response
    spur = 1;
    repeat (3) step();

    // single byte, fixed engine reply
    clear_logs();
    stim[0].push_back(9'h1A5);
    rx_plan.push_back(8'h3C);
    run("single", 200);
    check("single_grants", grant_log.size(), 1);
    check("single_rsp_cnt", rsp_data_log.size(), 1);
    if (rsp_data_log.size() > 0) begin
      check("single_rsp_data", rsp_data_log[0], 8'h3C);
      check("single_rsp_id", rsp_id_log[0], 0);
    end

    // asynchronous reset while requester 1 waits on the engine
    clear_logs();
    lat_min = 6; lat_max = 6;
    stim[1].push_back(9'h011);
    stim[1].push_back(9'h122);
    guard = 0;
    while (n_start == 0 && guard < 50) begin
      step();
      guard++;
    end
    check("mid_reached", n_start, 1);
    check("mid_cs_n", cs_n, 2'b01);
    rst = 1'b0;
    #1;
    check("mid_rst_cs_n", cs_n, 2'b11);
    check("mid_rst_start", eng_start, 0);
    check("mid_rst_ready", req_ready, 0);
    bench_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    lat_min = 1; lat_max = 3;

    // both requesters valid straight out of reset
    clear_logs();
    stim[0].push_back(9'h111);
    stim[0].push_back(9'h012);
    stim[0].push_back(9'h113);
    stim[1].push_back(9'h155);
    run("rr", 400);
    check("rr_grants", grant_log.size(), 3);
    if (grant_log.size() == 3) begin
      check("rr_order0", grant_log[0], 0);
      check("rr_order1", grant_log[1], 1);
      check("rr_order2", grant_log[2], 0);
    end

    // three-byte transaction on requester 1 while requester 0 waits
    clear_logs();
    stim[1].push_back(9'h001);
    stim[1].push_back(9'h002);
    stim[1].push_back(9'h103);
    stim[0].push_back(9'h1C4);
    run("multi", 400);
    check("multi_grants", grant_log.size(), 2);
    check("multi_rsp_cnt", rsp_id_log.size(), 4);
    if (grant_log.size() == 2 && rsp_id_log.size() == 4) begin
      check("multi_first", grant_log[0], 1);
      for (int i = 0; i < 3; i++) check("multi_rsp_id", rsp_id_log[i], 1);
      check("multi_rsp_id_last", rsp_id_log[3], 0);
    end

    // engine busy for 5 cycles in START
    clear_logs();
    stim[0].push_back(9'h177);
    busy_hold = 7;
    setup_extra = 5;
    run("busy", 200);
    check("busy_starts", n_start, 1);
    check("busy_readies", n_ready, 1);
    setup_extra = 0;

    // randomized traffic with intra-transaction gaps
    clear_logs();
    rand_gaps = 1;
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < N; i++) begin
      for (int t = 0; t < 6; t++) begin
        len = int'($urandom_range(4, 1));
        for (int j = 0; j < len; j++) stim[i].push_back({(j == len - 1), 8'($urandom)});
      end
    end
    run("random", 4000);
    check("random_grants", grant_log.size(), 12);
    rand_gaps = 0;

`ifdef SPI_ARB_TIMEOUT_EN
    // requester 0 stalls after a non-last byte
    clear_logs();
    expect_abort = 1;
    saw_err = 0;
    stim[0].push_back(9'h0AB);
    run("abort", 400);
    check("abort_err_seen", saw_err, 1);
    expect_abort = 0;
    clear_logs();
    stim[0].push_back(9'h1E1);
    stim[1].push_back(9'h1E2);
    run("after_abort", 300);
    if (grant_log.size() > 0) check("after_abort_first", grant_log[0], 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_txn_arbiter.md
Name: spi_txn_arbiter

Overview:
- Shares one SPI byte engine (an 8-bit, MSB-first shifter driven on the sclk domain) between NUM_REQ requesters, using round-robin arbitration.
- Sequences multi-byte transactions and owns one active-low chip select per requester.
- Applies setup and hold guard time around every transaction.
- Sits between the audio/ADC and config clients and the single SPI master in the FPGA top level.

Parameters:
- NUM_REQ, 2: number of requesters (2..8).
- CS_GUARD, 2: clk cycles that cs_n is held before the first byte and after the last byte (1..15).
- TIMEOUT, 255: clk cycles to wait for a requester's next byte. Used only with SPI_ARB_TIMEOUT_EN.

Ports:
- clk, in, 1: system clock; all logic on posedge.
- rst, in, 1: asynchronous reset, active-low.
- req_valid, in, NUM_REQ: requester i presents a byte.
- req_data, in, 8*NUM_REQ: byte for requester i, in bits [8i+7:8i].
- req_last, in, NUM_REQ: presented byte is the last one of the transaction.
- req_ready, out, NUM_REQ: one-cycle pulse; byte of requester i accepted.
- rsp_valid, out, 1: one-cycle pulse; received byte available.
- rsp_data, out, 8: received byte.
- rsp_id, out, $clog2(NUM_REQ): requester that owns rsp_data.
- cs_n, out, NUM_REQ: per-requester chip select, active-low.
- eng_start, out, 1: one-cycle pulse that starts the byte engine.
- eng_tx, out, 8: byte for the engine; valid while eng_start=1.
- eng_busy, in, 1: engine is shifting.
- eng_done, in, 1: one-cycle pulse; engine byte complete.
- eng_rx, in, 8: received byte; valid while eng_done=1.
- err, out, 1: one-cycle pulse on a timeout abort. Tied 0 when the feature is off.

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately, including mid-transaction):
  - cs_n all 1.
  - req_ready 0, rsp_valid 0, eng_start 0, err 0.
  - eng_tx 0, rsp_data 0, rsp_id 0.
  - rr_ptr 0, state IDLE.
- States: IDLE, SETUP, START, WAIT, NEXT, HOLD.
- IDLE:
  - If any req_valid is set, grant = first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - Latch grant, load guard counter with CS_GUARD, go to SETUP.
  - Grant is fixed for the whole transaction; other requesters see req_ready=0.
- SETUP: cs_n[grant]=0; decrement the counter each cycle; at 0, go to START.
- START: when req_valid[grant]=1 and eng_busy=0, in one cycle:
  - eng_start=1 and eng_tx=req_data[grant].
  - req_ready[grant]=1.
  - Latch req_last[grant]; go to WAIT.
  - Otherwise hold in START.
- WAIT: on eng_done=1:
  - Next cycle: rsp_valid=1, rsp_data=eng_rx, rsp_id=grant.
  - Go to HOLD if last was latched, else to NEXT.
- NEXT: cs_n stays low; go to START the next cycle. Gap between bytes is at least 2 clk cycles.
- HOLD:
  - cs_n[grant] stays 0 for CS_GUARD cycles, then goes to 1.
  - rr_ptr = (grant+1) mod NUM_REQ; return to IDLE.
  - The same cycle cs_n rises cannot grant; minimum of 1 idle cycle between transactions.
- At most one cs_n bit is ever 0.
- eng_done outside WAIT is ignored.
- eng_busy=1 in START stalls the start without dropping the byte.
- Single-byte transaction: req_last=1 on the first byte gives SETUP→START→WAIT→HOLD.
- Requester deasserts req_valid after grant: the arbiter waits in START/NEXT with cs_n held low (see Optional Feature).
- rr_ptr wraps from NUM_REQ-1 to 0.

Optional Feature:
- Macro: SPI_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs while in START with req_valid[grant]=0.
  - When it reaches TIMEOUT: err pulses 1 cycle, no byte is sent, go to HOLD (normal guard, cs_n released, rr_ptr advanced).
  - The counter clears on every accepted byte.
- Undefined: no counter; the arbiter waits indefinitely in START; err constant 0.

Test Plan:
- Reset mid-byte, rst low while in WAIT with cs_n[1]=0 → cs_n=2'b11 and eng_start=0 the same cycle; after release the state is IDLE and rr_ptr=0.
- NUM_REQ=2, req 0 sends 0xA5 with last=1, engine returns 0x3C:
  - cs_n[0] falls, then exactly 2 cycles to eng_start with eng_tx=0xA5.
  - rsp_valid with rsp_data=0x3C, rsp_id=0.
  - cs_n[0] rises 2 cycles after rsp.
- req 0 and req 1 both valid from reset → req 0 served first, then req 1, then req 0 again. Never two cs_n bits low together.
- Req 1 three-byte transaction 0x01, 0x02, 0x03 (last on 0x03) while req 0 is valid → cs_n[1] stays low across all 3 bytes, 3 rsp pulses with rsp_id=1, and req_ready[0]=0 throughout.
- eng_busy held 1 for 5 cycles in START → eng_start is delayed until busy falls; the byte is sent once and req_ready pulses once.
- With SPI_ARB_TIMEOUT_EN and TIMEOUT=10, req 0 sends a byte with last=0 and then drops req_valid → err pulses 10 cycles after entering START, cs_n[0] rises after the guard, and rr_ptr=1.
